// File: rtl/seq_div_pkg.sv
// Shared types and sizing constants for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } div_state_e;

  localparam int unsigned DefWidth    = 16;
  localparam int unsigned DefCntWidth = $clog2(DefWidth);

  // Iteration counter width for a given operand width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational iteration of radix-2 restoring division.
module div_restore_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  assign w_shifted = {i_rem, i_q_msb};
  assign w_diff    = w_shifted - {1'b0, i_divisor};

  // A clear MSB means the trial subtraction did not borrow.
  assign o_q_bit = ~w_diff[WIDTH];
  assign o_rem   = o_q_bit ? w_diff : w_shifted;

endmodule

// File: rtl/seq_divider16.sv
// Iterative unsigned divider: one quotient bit per clock behind a start/done handshake.
module seq_divider16
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             div_by_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  div_state_e       r_state;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_divisor;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_dbz;

  logic [WIDTH:0]   w_rem_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_q_next;
  logic             w_unused_rem_msb;

  // The restored remainder is always below the divisor, so its top bit never feeds back.
  assign w_unused_rem_msb = r_rem[WIDTH];

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem    (r_rem[WIDTH-1:0]),
    .i_q_msb  (r_q[WIDTH-1]),
    .i_divisor(r_divisor),
    .o_rem    (w_rem_next),
    .o_q_bit  (w_q_bit)
  );

  assign w_q_next = {r_q[WIDTH-2:0], w_q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_divisor <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            if (B != '0) begin
              r_state   <= StRun;
              r_busy    <= 1'b1;
              r_divisor <= B;
              r_q       <= A;
              r_rem     <= '0;
              r_cnt     <= CntW'(WIDTH - 1);
            end else begin
              // Divide by zero skips the iterations and reports all-ones / dividend.
              r_state   <= StDone;
              r_done    <= 1'b1;
              r_quot    <= '1;
              r_rem_out <= A;
              r_dbz     <= 1'b1;
            end
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state   <= StDone;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_quot    <= w_q_next;
            r_rem_out <= w_rem_next[WIDTH-1:0];
            r_dbz     <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign Quot        = r_quot;
  assign Rem         = r_rem_out;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: transaction-level model plus directed literal checks.
module tb_seq_divider16;

  localparam int unsigned W = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in  = '0;
  logic [W-1:0] b_in  = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         dbz;

  always #5 clk = ~clk;

  seq_divider16 #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (a_in),
    .B          (b_in),
    .busy       (busy),
    .done       (done),
    .Quot       (quot),
    .Rem        (rem),
    .div_by_zero(dbz)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: results come from plain / and %, timing from the latency rule.
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  bit           m_dbz  = 1'b0;
  logic [W-1:0] m_quot = '0;
  logic [W-1:0] m_rem  = '0;
  logic [W-1:0] p_quot = '0;
  logic [W-1:0] p_rem  = '0;
  int           m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_quot <= '0;
      m_rem  <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_quot <= p_quot;
          m_rem  <= p_rem;
          m_dbz  <= 1'b0;
        end
      end else if (start) begin
        if (b_in == '0) begin
          m_done <= 1'b1;
          m_quot <= '1;
          m_rem  <= a_in;
          m_dbz  <= 1'b1;
        end else begin
          m_busy <= 1'b1;
          m_left <= W;
          p_quot <= a_in / b_in;
          p_rem  <= a_in % b_in;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", busy, m_busy);
      check("model_done", done, m_done);
      check("model_quot", quot, m_quot);
      check("model_rem", rem, m_rem);
      check("model_dbz", dbz, m_dbz);
      check("busy_done_excl", busy & done, 1'b0);
    end
  end

  // Drive a request for one cycle, then scramble the operand buses.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
    a_in  = 16'hDEAD;
    b_in  = 16'h0000;
  endtask

  // k0 is the index of the current negedge counted from the request cycle.
  task automatic wait_done(input string name, input int k0, input int elat,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input bit ed);
    int k  = k0;
    int nb = 0;
    while (!done && k < 40) begin
      if (busy) nb++;
      @(negedge clk);
      k++;
    end
    check({name, "_done_seen"}, done, 1'b1);
    check({name, "_latency"}, k, elat);
    check({name, "_busy_cycles"}, nb, elat - k0);
    check({name, "_busy_at_done"}, busy, 1'b0);
    check({name, "_quot"}, quot, eq);
    check({name, "_rem"}, rem, er);
    check({name, "_dbz"}, dbz, ed);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[3];

  initial begin
    vecs[0] = '{a: 16'hFFFF, b: 16'd1,     q: 16'hFFFF, r: 16'd0};
    vecs[1] = '{a: 16'd5,    b: 16'd10,    q: 16'd0,    r: 16'd5};
    vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF,  q: 16'd1,    r: 16'd0};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quot", quot, 16'd0);
    check("rst_rem", rem, 16'd0);
    check("rst_dbz", dbz, 1'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    issue(16'd1000, 16'd7);
    wait_done("div_1000_7", 1, 17, 16'd142, 16'd6, 1'b0);

    // Back-to-back: request during the done cycle.
    issue(16'd50, 16'd4);
    check("b2b_held_quot", quot, 16'd142);
    check("b2b_held_rem", rem, 16'd6);
    wait_done("b2b_50_4", 1, 17, 16'd12, 16'd2, 1'b0);
    @(negedge clk);

    issue(16'd1234, 16'd0);
    wait_done("dbz_1234", 1, 1, 16'hFFFF, 16'd1234, 1'b1);
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), 1, 17, vecs[i].q, vecs[i].r, 1'b0);
      @(negedge clk);
    end

    // A second request while busy must be ignored.
    issue(16'd100, 16'd3);
    repeat (4) @(negedge clk);
    start = 1'b1;
    a_in  = 16'd9;
    b_in  = 16'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start", 6, 17, 16'd33, 16'd1, 1'b0);
    @(negedge clk);

    // Reset in the middle of an operation.
    issue(16'd1000, 16'd7);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_quot", quot, 16'd0);
    check("midrst_rem", rem, 16'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("postrst_done", done, 1'b0);
    check("postrst_quot", quot, 16'd0);
    issue(16'd1000, 16'd7);
    wait_done("restart_1000_7", 1, 17, 16'd142, 16'd6, 1'b0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
